alu_sequencer: RTL and testbench
================================

# alu_sequencer

- Sequences the 3-bit operand/opcode ALU datapath that drives the 6-bit LED bus.
- On `start`, latches one operand pair and steps the ALU through every opcode enabled in an 8-bit mask, holding each opcode for a programmable dwell.
- Captures each 6-bit result, folds it into a running signature, and pulses `done` when the sweep completes.
- Sits between the top-level pin wrapper and the ALU: it owns the ALU's `A`/`B`/`ctrl` inputs and samples its `Leds` output.

## Interface
Parameters:
- `DWELL_W`, default 4: width of the dwell field and dwell counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: abandon the sweep; return to IDLE on the next edge.
- `a_in` in 3: operand A; latched on accepted start.
- `b_in` in 3: operand B; latched on accepted start.
- `op_mask` in 8: bit k=1 runs opcode k; latched on accepted start.
- `dwell` in DWELL_W: extra hold cycles per opcode; latched on accepted start.
- `alu_a` out 3: registered operand A to the ALU.
- `alu_b` out 3: registered operand B to the ALU.
- `alu_ctrl` out 3: registered opcode to the ALU; equals the internal `op_idx`.
- `alu_leds` in 6: combinational ALU result.
- `leds_out` out 6: last captured result.
- `signature` out 6: running signature of the current or last sweep.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a completed sweep.

## Operation
States: IDLE, SEEK, DRIVE, CAPTURE, DONE.

- IDLE
  - `start`=1: latch operands, mask and dwell; `op_idx`←0; `signature`←0; go to SEEK.
- SEEK (tests one mask bit per cycle)
  - `mask[op_idx]`=1: load the dwell counter with `dwell`; go to DRIVE.
  - Bit clear and `op_idx`=7: go to DONE.
  - Bit clear otherwise: `op_idx`+1; stay in SEEK.
- DRIVE
  - Counter≠0: decrement it.
  - Counter=0: go to CAPTURE.
- CAPTURE (`alu_ctrl` still equals `op_idx`)
  - `leds_out`←`alu_leds`.
  - `signature`←{`signature[4:0]`, `signature[5]`} ^ `alu_leds`, i.e. rotate left by 1, then XOR.
  - `op_idx`=7: go to DONE; otherwise `op_idx`+1 and go to SEEK.
- DONE: `done`=1 for this cycle only; go to IDLE.

Boundary and priority rules:
- Priority: `rst` > `abort` > normal FSM.
- `abort` in any non-IDLE state goes to IDLE; `done` is not asserted; `leds_out` and `signature` keep their values.
- `start` while `busy` is ignored, including during DONE.
- `start` and `abort` high together in IDLE: `abort` wins, so no sweep starts.
- `op_mask`=0: sweep completes with `signature`=0; `leds_out` is unchanged.
- Counter and `op_idx` arithmetic: `op_idx` never wraps, because 7 always exits to DONE.

## Timing
- Reset values: state IDLE; `alu_a`, `alu_b`, `alu_ctrl`, `leds_out` and `signature` all 0; `busy`=0; `done`=0.
- `start` is sampled on edge E0; `busy`=1 from the cycle after E0.
- Each enabled opcode holds DRIVE for `dwell`+1 cycles, then CAPTURE for 1 cycle.
- With n enabled opcodes, `busy` is high for 8 + n·(`dwell`+2) cycles before DONE, plus the DONE cycle.
- `done` is high in the DONE cycle; `busy` falls the following cycle.
- The ALU is combinational, so the result is stable by CAPTURE. `alu_leds` is sampled only at the end of the CAPTURE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `alu_seq_pkg` holds:
  - State enum.
  - Constants `OP_W`=3, `LED_W`=6, `NUM_OPS`=8.
  - A rotate-left-1 function for the signature.
- One sub-module, `seq_dwell_timer`:
  - Inputs: `load`, `value`.
  - Output: `expired`, high when the count is 0.
  - Down-counter, width DWELL_W.

## Test plan
Every scenario uses a bench stub ALU: `alu_leds` = {`alu_ctrl`, `alu_a` ^ `alu_b`}.

1. a=5, b=3, mask=8'h01, dwell=0 → `leds_out`=6'h06, `signature`=6'h06, `busy` high 10 cycles, then `done` for 1 cycle.
2. a=5, b=3, mask=8'h81, dwell=0 → `leds_out`=6'h3E, `signature`=6'h32, `busy` high 12 cycles plus DONE.
3. mask=8'h00 → 8 busy cycles, then `done`; `signature`=0; `leds_out` holds its prior value.
4. mask=8'h02, dwell=3 → `alu_ctrl`=1 for 4 DRIVE cycles plus CAPTURE; 13 busy cycles; `leds_out`={001, a^b}.
5. mask=8'hFF, assert `abort` during the DRIVE of op 3 → IDLE next cycle; `done` never asserts; `leds_out` holds the op-2 result. A re-pulsed `start` during the run has no effect.
6. `rst` asserted mid-sweep → next cycle all outputs are at their reset values; a new `start` then runs normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_pkg
// Purpose: Shared types, widths and helpers for the ALU opcode sequencer.
//          Holds the sequencer state encoding, datapath widths and the
//          rotate-left-by-one used when folding results into the signature.
// Rev    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  localparam int OP_W    = 3;  // ALU operand / opcode width
  localparam int LED_W   = 6;  // ALU result (LED bus) width
  localparam int NUM_OPS = 8;  // number of opcodes, one mask bit each

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEEK    = 3'd1,
    S_DRIVE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

  // Rotate left by one bit; the MSB wraps into the LSB.
  function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module : seq_dwell_timer
// Purpose: Loadable down-counter that measures how long the sequencer holds
//          each opcode on the ALU. Counts down to zero and stops there.
// Ports  : clk, rst      - clock, synchronous active-high reset
//          load, value   - load 'value' into the counter (wins over counting)
//          expired       - high while the count is zero
// Rev    : 1.0  initial release
// ============================================================================
module seq_dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expired
);

  logic [DWELL_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_sequencer
// Purpose: Drives a combinational 3-bit ALU through every opcode enabled in
//          an 8-bit mask, holding each for a programmable dwell, capturing
//          each 6-bit result and folding it into a rotate/XOR signature.
// Ports  : clk, rst             - clock, synchronous active-high reset
//          start, abort         - begin a sweep (IDLE only) / abandon it
//          a_in, b_in           - operands, latched on accepted start
//          op_mask, dwell       - opcode enables and extra hold cycles
//          alu_a, alu_b, alu_ctrl - registered ALU inputs
//          alu_leds             - combinational ALU result
//          leds_out, signature  - last captured result, running signature
//          busy, done           - sweep in progress, end-of-sweep pulse
// Rev    : 1.0  initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         a_in,
  input  logic [2:0]         b_in,
  input  logic [7:0]         op_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         alu_a,
  output logic [2:0]         alu_b,
  output logic [2:0]         alu_ctrl,
  input  logic [5:0]         alu_leds,
  output logic [5:0]         leds_out,
  output logic [5:0]         signature,
  output logic               busy,
  output logic               done
);

  localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

  seq_state_t           state_q,  state_d;
  logic [OP_W-1:0]      a_q,      a_d;
  logic [OP_W-1:0]      b_q,      b_d;
  logic [OP_W-1:0]      op_idx_q, op_idx_d;
  logic [NUM_OPS-1:0]   mask_q,   mask_d;
  logic [DWELL_W-1:0]   dwell_q,  dwell_d;
  logic [LED_W-1:0]     leds_q,   leds_d;
  logic [LED_W-1:0]     sig_q,    sig_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  logic                 timer_load;
  logic                 timer_expired;

  seq_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (dwell_q),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_idx_d   = op_idx_q;
    mask_d     = mask_q;
    dwell_d    = dwell_q;
    leds_d     = leds_q;
    sig_d      = sig_q;
    timer_load = 1'b0;

    // Abort outranks everything, including a simultaneous start in IDLE,
    // and suppresses any capture so leds_out/signature keep their values.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_d      = a_in;
            b_d      = b_in;
            mask_d   = op_mask;
            dwell_d  = dwell;
            op_idx_d = '0;
            sig_d    = '0;
            state_d  = S_SEEK;
          end
        end
        S_SEEK: begin
          if (mask_q[op_idx_q]) begin
            timer_load = 1'b1;
            state_d    = S_DRIVE;
          end else if (op_idx_q == LAST_OP) begin
            state_d = S_DONE;
          end else begin
            op_idx_d = op_idx_q + OP_W'(1);
          end
        end
        S_DRIVE: begin
          if (timer_expired) begin
            state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          leds_d = alu_leds;
          sig_d  = rotl1(sig_q) ^ alu_leds;
          if (op_idx_q == LAST_OP) begin
            state_d = S_DONE;
          end else begin
            op_idx_d = op_idx_q + OP_W'(1);
            state_d  = S_SEEK;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Status flags are registered copies of the next state so that they
    // line up exactly with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_idx_q <= '0;
      mask_q   <= '0;
      dwell_q  <= '0;
      leds_q   <= '0;
      sig_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_idx_q <= op_idx_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      leds_q   <= leds_d;
      sig_q    <= sig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = op_idx_q;
  assign leds_out  = leds_q;
  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_sequencer
// Purpose: Directed self-checking bench for alu_sequencer with a stub ALU
//          whose result is {alu_ctrl, alu_a ^ alu_b}.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] a_in;
  logic [2:0] b_in;
  logic [7:0] op_mask;
  logic [3:0] dwell;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [5:0] alu_leds;
  logic [5:0] leds_out;
  logic [5:0] signature;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stub ALU
  assign alu_leds = {alu_ctrl, alu_a ^ alu_b};

  alu_sequencer #(
    .DWELL_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .a_in      (a_in),
    .b_in      (b_in),
    .op_mask   (op_mask),
    .dwell     (dwell),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_leds  (alu_leds),
    .leds_out  (leds_out),
    .signature (signature),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch a sweep and follow it to the done pulse. Returns the number of
  // busy cycles before DONE and the number of busy cycles with alu_ctrl==1.
  task automatic run_sweep(input string tag, input logic [2:0] a, input logic [2:0] b,
                           input logic [7:0] m, input logic [3:0] dw,
                           input bit start_in_done,
                           output int busy_n, output int ctrl1_n);
    bit timed_out;
    @(negedge clk);
    a_in = a; b_in = b; op_mask = m; dwell = dw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; ctrl1_n = 0; timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_n++;
      if (busy && alu_ctrl == 3'd1) ctrl1_n++;
      @(negedge clk);
    end
    check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    if (!timed_out) begin
      check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      if (start_in_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int  bn;
    int  c1;
    bit  seen_done;
    bit  found;
    bit  pulsed;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    a_in = '0; b_in = '0; op_mask = '0; dwell = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", {8'd0, alu_a, alu_b, alu_ctrl, leds_out, signature, busy, done},
          32'd0);

    // 1: single opcode 0, no dwell: 5^3=6, ctrl 0 -> 0x06
    run_sweep("t1", 3'd5, 3'd3, 8'h01, 4'd0, 1'b0, bn, c1);
    check("t1_busy_cycles", bn, 32'd10);
    check("t1_leds", leds_out, 32'h06);
    check("t1_sig", signature, 32'h06);

    // 2: opcodes 0 and 7: 0x06 then 0x3E; sig = rotl(06)^3E = 0C^3E = 32
    run_sweep("t2", 3'd5, 3'd3, 8'h81, 4'd0, 1'b0, bn, c1);
    check("t2_busy_cycles", bn, 32'd12);
    check("t2_leds", leds_out, 32'h3E);
    check("t2_sig", signature, 32'h32);

    // 3: empty mask; start held during DONE must not retrigger
    run_sweep("t3", 3'd1, 3'd2, 8'h00, 4'd5, 1'b1, bn, c1);
    check("t3_busy_cycles", bn, 32'd8);
    check("t3_sig", signature, 32'h00);
    check("t3_leds_hold", leds_out, 32'h3E);
    @(negedge clk);
    check("t3_no_restart", {31'd0, busy}, 32'd0);

    // 4: opcode 1 with dwell 3: ctrl==1 in SEEK(1) + 4 DRIVE + CAPTURE = 6
    run_sweep("t4", 3'd5, 3'd3, 8'h02, 4'd3, 1'b0, bn, c1);
    check("t4_busy_cycles", bn, 32'd13);
    check("t4_ctrl1_cycles", c1, 32'd6);
    check("t4_leds", leds_out, 32'h0E);
    check("t4_sig", signature, 32'h0E);

    // 5: full mask, abort during DRIVE of op 3. a^b = 2^7 = 5.
    // results 05, 0D, 15; sig: 05 -> 0A^0D=07 -> 0E^15=1B
    @(negedge clk);
    a_in = 3'd2; b_in = 3'd7; op_mask = 8'hFF; dwell = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0; found = 1'b0; pulsed = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) seen_done = 1'b1;
      if (alu_ctrl == 3'd1 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (alu_ctrl == 3'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("t5_reach_op3", {31'd0, found}, 32'd1);
    @(negedge clk);
    check("t5_drive_op3", alu_ctrl, 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy_after_abort", {31'd0, busy}, 32'd0);
    check("t5_leds_op2", leds_out, 32'h15);
    check("t5_sig", signature, 32'h1B);
    repeat (3) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    check("t5_no_done", {31'd0, seen_done}, 32'd0);
    check("t5_stays_idle", {31'd0, busy}, 32'd0);

    // start+abort together in IDLE: no sweep, operands not latched
    a_in = 3'd7; b_in = 3'd7; op_mask = 8'hFF; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", {31'd0, busy}, 32'd0);
    check("abort_wins_a", alu_a, 32'd2);

    // 6: reset mid-sweep, then a normal run
    a_in = 3'd1; b_in = 3'd6; op_mask = 8'hFF; dwell = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_outputs",
          {8'd0, alu_a, alu_b, alu_ctrl, leds_out, signature, busy, done}, 32'd0);
    // opcode 4 only, 4^4=0 -> {100,000}=0x20; busy = 8 + 1*(2+2) = 12
    run_sweep("t6", 3'd4, 3'd4, 8'h10, 4'd2, 1'b0, bn, c1);
    check("t6_busy_cycles", bn, 32'd12);
    check("t6_leds", leds_out, 32'h20);
    check("t6_sig", signature, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
